// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and the 3-bit operation codes.
package alu_pkg;

   localparam int ALU_DW = 32;

   typedef enum logic [2:0] {
      FN_ADD = 3'd0,
      FN_SUB = 3'd1,
      FN_AND = 3'd2,
      FN_OR  = 3'd3,
      FN_XOR = 3'd4,
      FN_SLL = 3'd5,
      FN_SRL = 3'd6,
      FN_SLT = 3'd7
   } alu_func_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle for the ALU; master drives operands, slave returns the result.
interface alu_if #(parameter int DW = 32);

   logic [DW-1:0] data_a;
   logic [DW-1:0] data_b;
   logic [2:0]    func;
   logic [DW-1:0] data_y;
   logic          data_c;

   modport master (output data_a, output data_b, output func,
                   input  data_y, input  data_c);

   modport slave  (input  data_a, input  data_b, input  func,
                   output data_y, output data_c);

endinterface

// File: rtl/alu_shifter.sv
// Combinational logical barrel shifter with last-bit-shifted-out flag.
// Zero latency, no backpressure.
module alu_shifter #(
   parameter int DW  = 32,
   parameter int SHW = $clog2(DW)
) (
   input  logic [DW-1:0]  a_i,
   input  logic [SHW-1:0] sh_i,
   input  logic           right_i,
   output logic [DW-1:0]  y_o,
   output logic           out_o
);

   logic [DW:0] left_ext;
   logic [DW:0] right_ext;

   // One guard bit on the exit side catches the last bit shifted out; it stays 0 for sh=0.
   always_comb begin
      left_ext  = {1'b0, a_i} << sh_i;
      right_ext = {a_i, 1'b0} >> sh_i;
      y_o       = left_ext[DW-1:0];
      out_o     = left_ext[DW];
      if (right_i) begin
         y_o   = right_ext[DW:1];
         out_o = right_ext[0];
      end
   end

endmodule

// File: rtl/alu.sv
// 32-bit ALU: add/sub/logic/shift/slt with a registered result and carry flag.
// Latency 1 cycle, accepts an operation every cycle, no backpressure.
module alu
   import alu_pkg::*;
#(
   parameter int DW = ALU_DW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_data_a,
   input  logic [DW-1:0] i_data_b,
   input  logic [2:0]    i_func,
   output logic [DW-1:0] o_data_y,
   output logic          o_data_c
);

   localparam int SHW = $clog2(DW);

   alu_func_e     func;
   logic          sub;
   logic [DW-1:0] b_op;
   logic [DW:0]   sum;
   logic          slt;
   logic [DW-1:0] sh_y;
   logic          sh_out;
   logic [DW-1:0] y_d, y_q;
   logic          c_d, c_q;

   assign func = alu_func_e'(i_func);

   // SUB and SLT share the single adder as A + ~B + 1; bit DW is then the inverted borrow.
   assign sub  = (func == FN_SUB) || (func == FN_SLT);
   assign b_op = sub ? ~i_data_b : i_data_b;
   assign sum  = {1'b0, i_data_a} + {1'b0, b_op} + {{DW{1'b0}}, sub};
   assign slt  = (i_data_a[DW-1] ^ i_data_b[DW-1]) ? i_data_a[DW-1] : sum[DW-1];

   alu_shifter #(.DW(DW), .SHW(SHW)) u_shifter (
      .a_i     (i_data_a),
      .sh_i    (i_data_b[SHW-1:0]),
      .right_i (func == FN_SRL),
      .y_o     (sh_y),
      .out_o   (sh_out)
   );

   always_comb begin
      y_d = '0;
      c_d = 1'b0;
      case (func)
         FN_ADD: begin y_d = sum[DW-1:0]; c_d = sum[DW];  end
         FN_SUB: begin y_d = sum[DW-1:0]; c_d = ~sum[DW]; end
         FN_AND: y_d = i_data_a & i_data_b;
         FN_OR:  y_d = i_data_a | i_data_b;
         FN_XOR: y_d = i_data_a ^ i_data_b;
         FN_SLL, FN_SRL: begin y_d = sh_y; c_d = sh_out; end
         FN_SLT: y_d = {{(DW-1){1'b0}}, slt};
         default: begin y_d = '0; c_d = 1'b0; end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         y_q <= '0;
         c_q <= 1'b0;
      end else begin
         y_q <= y_d;
         c_q <= c_d;
      end
   end

   assign o_data_y = y_q;
   assign o_data_c = c_q;

endmodule

// File: tb/tb_alu.sv
// Randomized bench for alu against an arithmetic reference, plus pinned literal cases.
module tb_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_if #(.DW(32)) bus ();

   alu #(.DW(32)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_data_a (bus.data_a),
      .i_data_b (bus.data_b),
      .i_func   (bus.func),
      .o_data_y (bus.data_y),
      .o_data_c (bus.data_c)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   bit          chk_en      = 1'b0;
   logic [31:0] mdl_y;
   logic        mdl_c;

   // Returns {c, y} straight from the operation definitions.
   function automatic logic [32:0] ref_op(logic [31:0] a, logic [31:0] b, logic [2:0] f);
      int sh;
      sh = int'(b[4:0]);
      case (f)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {(a < b), a - b};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return (sh == 0) ? {1'b0, a} : {a[32-sh], a << sh};
         3'd6: return (sh == 0) ? {1'b0, a} : {a[sh-1], a >> sh};
         default: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      endcase
   endfunction

   task automatic check(string name, logic [31:0] got_y, logic got_c,
                        logic [31:0] exp_y, logic exp_c);
      vectors++;
      if (got_y !== exp_y || got_c !== exp_c) begin
         miscompares++;
         $display("FAIL %s: got y=%h c=%b, expected y=%h c=%b", name, got_y, got_c, exp_y, exp_c);
      end
   endtask

   task automatic drive(logic [31:0] a, logic [31:0] b, logic [2:0] f);
      bus.data_a = a;
      bus.data_b = b;
      bus.func   = f;
   endtask

   task automatic lit(string name, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                      logic [31:0] ey, logic ec);
      @(negedge clk);
      drive(a, b, f);
      @(posedge clk);
      #1;
      check(name, bus.data_y, bus.data_c, ey, ec);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_y <= '0;
         mdl_c <= 1'b0;
      end else begin
         {mdl_c, mdl_y} <= ref_op(bus.data_a, bus.data_b, bus.func);
      end
   end

   always @(negedge clk) begin
      if (chk_en) check("model", bus.data_y, bus.data_c, mdl_y, mdl_c);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] sweep_y [8];
   logic        sweep_c [8];

   initial begin
      sweep_y = '{32'h6666_6666, 32'h4444_4444, 32'h1111_1111, 32'h5555_5555,
                  32'h4444_4444, 32'hAAAA_0000, 32'h0000_2AAA, 32'h0000_0000};
      sweep_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
      #12;
      check("reset_state", bus.data_y, bus.data_c, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", bus.data_y, bus.data_c, 32'h0, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      lit("add",       32'h5555_5555, 32'h1111_1111, 3'd0, 32'h6666_6666, 1'b0);
      lit("add_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFE, 1'b1);
      lit("sub_borrow",32'h1111_1111, 32'hAAAA_AAAA, 3'd1, 32'h6666_6667, 1'b1);
      lit("sub_equal", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000, 1'b0);
      lit("and",       32'h5555_5555, 32'h1111_1111, 3'd2, 32'h1111_1111, 1'b0);
      lit("or",        32'h5555_5555, 32'h1111_1111, 3'd3, 32'h5555_5555, 1'b0);
      lit("xor",       32'h5555_5555, 32'h1111_1111, 3'd4, 32'h4444_4444, 1'b0);
      lit("sll31",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 32'h8000_0000, 1'b1);
      lit("srl10",     32'h1111_1111, 32'hAAAA_AAAA, 3'd6, 32'h0004_4444, 1'b0);
      lit("srl_sh0",   32'h1234_5678, 32'hFFFF_FFE0, 3'd6, 32'h1234_5678, 1'b0);
      lit("sll_sh0",   32'h8765_4321, 32'h0000_0020, 3'd5, 32'h8765_4321, 1'b0);
      lit("slt_pos",   32'h1111_1111, 32'hAAAA_AAAA, 3'd7, 32'h0000_0000, 1'b0);
      lit("slt_neg",   32'hAAAA_AAAA, 32'h1111_1111, 3'd7, 32'h0000_0001, 1'b0);

      for (int f = 0; f < 8; f++) begin
         lit($sformatf("sweep_f%0d", f), 32'h5555_5555, 32'h1111_1111, 3'(f),
             sweep_y[f], sweep_c[f]);
      end

      for (int i = 0; i < 2000; i++) begin
         logic [31:0] rb;
         @(negedge clk);
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) rb[4:0] = 5'd0;
         drive($urandom, rb, 3'($urandom_range(0, 7)));
      end

      @(negedge clk);
      drive(32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
      @(posedge clk);
      #1;
      check("pre_rst", bus.data_y, bus.data_c, 32'h0000_0000, 1'b1);
      drive(32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", bus.data_y, bus.data_c, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_discard", bus.data_y, bus.data_c, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      lit("post_rst", 32'h0000_0003, 32'h0000_0004, 3'd0, 32'h0000_0007, 1'b0);

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         drive($urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      @(negedge clk);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have port i_data_a, input, 32 bits: operand A.
REQ-004 The module SHALL have port i_data_b, input, 32 bits: operand B; bits [4:0] are the shift amount for shift operations.
REQ-005 The module SHALL have port i_func, input, 3 bits: operation select.
REQ-006 The module SHALL have port o_data_y, output, 32 bits: registered result.
REQ-007 The module SHALL have port o_data_c, output, 1 bit: registered carry/borrow/shift-out flag.
REQ-008 The module SHALL have parameter DW, default 32: data width; only 32 is required to be supported.

Function
REQ-009 Inputs SHALL be sampled on each rising i_clk edge, and o_data_y/o_data_c SHALL hold the result one cycle later, with a latency of exactly 1 clock.
REQ-010 The module SHALL accept a new operation every cycle, with no handshake and no stall.
REQ-011 i_func=0 (ADD) SHALL produce y=A+B mod 2^32 and c=carry-out of bit 31.
REQ-012 i_func=1 (SUB) SHALL produce y=A-B mod 2^32 and c=1 when A<B unsigned (borrow), otherwise 0.
REQ-013 i_func=2 (AND), 3 (OR) and 4 (XOR) SHALL produce the bitwise result with c=0.
REQ-014 i_func=5 (SLL) SHALL produce y=A<<B[4:0] with zero fill, and c=last bit shifted out (A[32-sh]); c=0 when sh=0.
REQ-015 i_func=6 (SRL) SHALL produce y=A>>B[4:0] with zero fill, and c=last bit shifted out (A[sh-1]); c=0 when sh=0.
REQ-016 i_func=7 (SLT) SHALL produce y=32'h1 if A<B signed (two's complement), otherwise 32'h0, with c=0.
REQ-017 B[31:5] SHALL be ignored for shift operations.
REQ-018 X/Z on inputs is outside the contract, and no flag other than c SHALL be produced.

Reset
REQ-019 Asserting i_rst SHALL immediately force o_data_y=32'h0 and o_data_c=0, independent of i_clk.
REQ-020 While i_rst is high, the outputs SHALL stay at zero.
REQ-021 After i_rst deasserts, the first result SHALL appear one cycle after the first rising edge with i_rst low.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result.

Structure
REQ-023 The shared package alu_pkg SHALL hold the 3-bit function codes (ADD, SUB, AND, OR, XOR, SLL, SRL, SLT) and the width constant.
REQ-024 The barrel shifter SHALL be implemented in one sub-module, alu_shifter, providing a combinational left/right shift with shift-out bit.
REQ-025 The add/subtract path SHALL use a single shared 33-bit adder.
REQ-026 The result mux SHALL be combinational and SHALL be followed by one output register stage.

Verification
REQ-027 ADD: A=5555_5555, B=1111_1111 -> next cycle y=6666_6666, c=0; A=FFFF_FFFF, B=FFFF_FFFF -> y=FFFF_FFFE, c=1.
REQ-028 SUB: A=1111_1111, B=AAAA_AAAA -> y=6666_6667, c=1; A=B=FFFF_FFFF -> y=0, c=0.
REQ-029 Logic: A=5555_5555, B=1111_1111 -> AND 1111_1111, OR 5555_5555, XOR 4444_4444, c=0 each.
REQ-030 Shifts: SLL A=FFFF_FFFF, B=FFFF_FFFF (sh=31) -> y=8000_0000, c=1; SRL A=1111_1111, B=AAAA_AAAA (sh=10) -> y=0004_4444, c=0; sh=0 -> y=A, c=0.
REQ-031 SLT: A=1111_1111, B=AAAA_AAAA -> y=0; A=AAAA_AAAA, B=1111_1111 -> y=1.
REQ-032 Back-to-back sweep of i_func 0..7 on consecutive cycles -> each result appears exactly one cycle later; asserting i_rst between clock edges -> outputs 0 immediately.
